// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer pixel writer: default geometry,
// writer FSM states and the RGB888 -> RGB565 packing helper.
package fb_pkg;

   localparam int FB_W_DEF       = 160;
   localparam int FB_H_DEF       = 120;
   localparam int FIFO_DEPTH_DEF = 16;
   localparam int ADDR_W_DEF     = 15;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN,
      DONE
   } fb_state_e;

   // Keeps the top bits of each channel: {R[7:3], G[7:2], B[7:3]}.
   function automatic logic [15:0] rgb888_to_565(input logic [23:0] c);
      return {c[23:19], c[15:10], c[7:3]};
   endfunction

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Framebuffer write port: one valid/ready handshake carrying address and RGB565 data.
interface fb_pixel_writer_if #(
   parameter int ADDR_W = 15
) ();

   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_data;

   modport master (
      output mem_valid,
      output mem_addr,
      output mem_data,
      input  mem_ready
   );

   modport slave (
      input  mem_valid,
      input  mem_addr,
      input  mem_data,
      output mem_ready
   );

endinterface

// File: rtl/fb_pixel_writer_px_fifo.sv
// Synchronous pixel FIFO. The head entry is visible on dout while not empty;
// push is ignored when full and pop is ignored when empty.
module px_fifo #(
   parameter  int WIDTH = 31,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem[rd_ptr_q];

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; the pointers and count alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/fb_pixel_writer.sv
// Clips the rasterizer pixel stream to the framebuffer, packs {addr, RGB565},
// buffers it and issues framebuffer writes; pulses frame_done once the frame is written.
module fb_pixel_writer
   import fb_pkg::*;
#(
   parameter int FB_W       = FB_W_DEF,
   parameter int FB_H       = FB_H_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int ADDR_W     = ADDR_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      raster_start,
   input  logic                      pix_valid,
   input  logic [7:0]                px,
   input  logic [7:0]                py,
   input  logic [23:0]               pix_color,
   input  logic                      raster_done,
   output logic                      in_ready,
   fb_pixel_writer_if.master         mem,
   output logic                      frame_done,
   output logic                      overflow,
   output logic [15:0]               clip_count
);

   localparam int EW = ADDR_W + 16;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic              in_bounds;
   logic [ADDR_W-1:0] pix_addr;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [EW-1:0]     fifo_dout;
   logic [CW-1:0]     fifo_count;
   logic              out_load;

   logic              mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_data_q, mem_data_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       clip_count_q, clip_count_d;
   fb_state_e         state_q, state_d;

   // px/py are zero-extended so FB_W/FB_H up to 256 compare correctly.
   assign in_bounds = (32'(px) < FB_W) && (32'(py) < FB_H);
   assign pix_addr  = ADDR_W'(py) * ADDR_W'(FB_W) + ADDR_W'(px);
   assign fifo_push = pix_valid && in_bounds && !fifo_full;

   // The output register refills whenever it is empty or its write is being accepted.
   assign out_load  = !mem_valid_q || mem.mem_ready;
   assign fifo_pop  = out_load && !fifo_empty;

   px_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   ({pix_addr, rgb888_to_565(pix_color)}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      if (out_load) begin
         mem_valid_d = !fifo_empty;
         if (!fifo_empty) {mem_addr_d, mem_data_d} = fifo_dout;
      end
   end

   // A new frame clears the per-frame statistics before this cycle's events count.
   always_comb begin
      clip_count_d = raster_start ? 16'd0 : clip_count_q;
      overflow_d   = overflow_q && !raster_start;
      if (pix_valid && !in_bounds && clip_count_d != 16'hFFFF)
         clip_count_d = clip_count_d + 16'd1;
      if (pix_valid && in_bounds && fifo_full)
         overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_valid_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         overflow_q   <= 1'b0;
         clip_count_q <= '0;
      end else begin
         mem_valid_q  <= mem_valid_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         overflow_q   <= overflow_d;
         clip_count_q <= clip_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = IDLE;
         ACTIVE:  if (raster_done) state_d = DRAIN;
         DRAIN:   if (fifo_count == '0 && !mem_valid_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (raster_start) state_d = ACTIVE;
   end

   // A restart landing on the DONE cycle cancels the old frame's pulse.
   assign frame_done    = (state_q == DONE) && !raster_start;
   assign in_ready      = !fifo_full;
   assign overflow      = overflow_q;
   assign clip_count    = clip_count_q;
   assign mem.mem_valid = mem_valid_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_data  = mem_data_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: a table of single-pixel frames plus
// hand-written sequences for reset, latency, backpressure, restart and a full triangle.
module tb_fb_pixel_writer;

   localparam int ADDR_W = 15;
   localparam int FB_W   = 160;
   localparam int FB_H   = 120;

   logic        clk = 1'b0;
   logic        rst;
   logic        raster_start, pix_valid, raster_done;
   logic [7:0]  px, py;
   logic [23:0] pix_color;
   logic        in_ready, frame_done, overflow;
   logic [15:0] clip_count;

   fb_pixel_writer_if #(.ADDR_W(ADDR_W)) mem_if ();

   fb_pixel_writer #(
      .FB_W       (FB_W),
      .FB_H       (FB_H),
      .FIFO_DEPTH (16),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .raster_start (raster_start),
      .pix_valid    (pix_valid),
      .px           (px),
      .py           (py),
      .pix_color    (pix_color),
      .raster_done  (raster_done),
      .in_ready     (in_ready),
      .mem          (mem_if),
      .frame_done   (frame_done),
      .overflow     (overflow),
      .clip_count   (clip_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
      int                cyc;
   } wr_t;

   typedef struct {
      logic [7:0]        x;
      logic [7:0]        y;
      logic [23:0]       c;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
      logic [15:0]       clips;
   } vec_t;

   int  n_vec = 0;
   int  n_fail = 0;
   int  cycle = 0;
   int  done_cnt = 0;
   int  done_cyc = 0;
   bit  rand_ready = 1'b0;
   wr_t wr_q[$];
   bit  exp_map [FB_W*FB_H];
   bit  seen    [FB_W*FB_H];

   always @(posedge clk) cycle++;

   // Handshakes and frame_done are observed mid-cycle, when everything is settled.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (mem_if.mem_valid && mem_if.mem_ready)
            wr_q.push_back('{mem_if.mem_addr, mem_if.mem_data, cycle});
         if (frame_done) begin
            done_cnt++;
            done_cyc = cycle;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) mem_if.mem_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic start_frame();
      raster_start = 1'b1;
      step();
      raster_start = 1'b0;
   endtask

   task automatic send_px(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c);
      pix_valid = 1'b1;
      px        = x;
      py        = y;
      pix_color = c;
      step();
      pix_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int d0, input int budget);
      for (int i = 0; i < budget && done_cnt == d0; i++) step();
      check(name, done_cnt - d0, 1);
   endtask

   task automatic end_frame(input string name, input int budget);
      int d0;
      d0 = done_cnt;
      raster_done = 1'b1;
      step();
      raster_done = 1'b0;
      wait_done(name, d0, budget);
   endtask

   vec_t vt [8];

   initial begin
      int d0;
      int bad;
      int n_exp;
      logic [7:0]  k;
      logic [15:0] exp_d;

      vt[0] = '{8'd10,  8'd5,   24'hFF0000, 1'b1, 15'd810,   16'hF800, 16'd0};
      vt[1] = '{8'd0,   8'd0,   24'h00FF00, 1'b1, 15'd0,     16'h07E0, 16'd0};
      vt[2] = '{8'd159, 8'd119, 24'h0000FF, 1'b1, 15'd19199, 16'h001F, 16'd0};
      vt[3] = '{8'd160, 8'd0,   24'hFFFFFF, 1'b0, 15'd0,     16'h0000, 16'd1};
      vt[4] = '{8'd0,   8'd120, 24'hFFFFFF, 1'b0, 15'd0,     16'h0000, 16'd1};
      vt[5] = '{8'd255, 8'd255, 24'hFFFFFF, 1'b0, 15'd0,     16'h0000, 16'd1};
      vt[6] = '{8'd37,  8'd64,  24'h123456, 1'b1, 15'd10277, 16'h11AA, 16'd0};
      vt[7] = '{8'd159, 8'd0,   24'hFFFFFF, 1'b1, 15'd159,   16'hFFFF, 16'd0};

      rst = 1'b0;
      raster_start = 1'b0;
      raster_done = 1'b0;
      pix_valid = 1'b1;
      px = 8'd10;
      py = 8'd5;
      pix_color = 24'hFF0000;
      mem_if.mem_ready = 1'b1;

      // Reset held with pixels arriving: nothing may be buffered or counted.
      for (int i = 0; i < 3; i++) begin
         if (i == 2) px = 8'd200;
         step();
         check("rst_mem_valid", mem_if.mem_valid, 0);
      end
      pix_valid = 1'b0;
      rst = 1'b1;
      step();
      check("rst_in_ready", in_ready, 1);
      check("rst_clip", clip_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_addr", mem_if.mem_addr, 0);
      check("rst_data", mem_if.mem_data, 0);
      check("rst_frame_done", frame_done, 0);
      step();
      check("rst_no_write", wr_q.size(), 0);

      // Table: one pixel per frame.
      for (int v = 0; v < 8; v++) begin
         wr_q.delete();
         start_frame();
         send_px(vt[v].x, vt[v].y, vt[v].c);
         end_frame($sformatf("vec%0d_done", v), 50);
         check($sformatf("vec%0d_clip", v), clip_count, vt[v].clips);
         check($sformatf("vec%0d_nwr", v), wr_q.size(), vt[v].wr);
         if (vt[v].wr && wr_q.size() > 0) begin
            check($sformatf("vec%0d_addr", v), wr_q[0].addr, vt[v].addr);
            check($sformatf("vec%0d_data", v), wr_q[0].data, vt[v].data);
         end
      end

      // Latency: sampled at E0, mem_valid visible only after E1.
      wr_q.delete();
      start_frame();
      send_px(8'd10, 8'd5, 24'hFF0000);
      check("lat_e0_valid", mem_if.mem_valid, 0);
      step();
      check("lat_e1_valid", mem_if.mem_valid, 1);
      check("lat_e1_addr", mem_if.mem_addr, 810);
      check("lat_e1_data", mem_if.mem_data, 16'hF800);
      end_frame("lat_done", 50);
      check("lat_nwr", wr_q.size(), 1);

      // Three clipped pixels in one frame.
      wr_q.delete();
      start_frame();
      send_px(8'd160, 8'd0, 24'h123456);
      send_px(8'd0, 8'd120, 24'h123456);
      send_px(8'd255, 8'd255, 24'h123456);
      end_frame("clip3_done", 50);
      check("clip3_count", clip_count, 3);
      check("clip3_nwr", wr_q.size(), 0);

      // Backpressure: 17 pixels fill register + FIFO, the 18th overflows.
      wr_q.delete();
      mem_if.mem_ready = 1'b0;
      start_frame();
      for (int i = 0; i < 17; i++) begin
         k = 8'(i);
         send_px(k, 8'd1, {k[4:0], 3'b101, k[5:0], 2'b11, k[4:0], 3'b010});
      end
      check("bp_in_ready", in_ready, 0);
      check("bp_overflow0", overflow, 0);
      check("bp_valid", mem_if.mem_valid, 1);
      send_px(8'd17, 8'd1, 24'hFFFFFF);
      check("bp_overflow1", overflow, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_addr", mem_if.mem_addr, 160);
         check("bp_hold_data", mem_if.mem_data, 0);
      end
      mem_if.mem_ready = 1'b1;
      end_frame("bp_done", 100);
      check("bp_nwr", wr_q.size(), 17);
      bad = 0;
      for (int i = 0; i < 17 && i < wr_q.size(); i++) begin
         k = 8'(i);
         exp_d = {k[4:0], k[5:0], k[4:0]};
         if (wr_q[i].addr !== ADDR_W'(160 + i) || wr_q[i].data !== exp_d) bad++;
      end
      check("bp_order", bad, 0);
      check("bp_overflow_sticky", overflow, 1);

      // Last pixel together with raster_done is still written before frame_done.
      wr_q.delete();
      start_frame();
      check("sim_overflow_cleared", overflow, 0);
      d0 = done_cnt;
      pix_valid = 1'b1;
      px = 8'd3;
      py = 8'd3;
      pix_color = 24'hFFFFFF;
      raster_done = 1'b1;
      step();
      pix_valid = 1'b0;
      raster_done = 1'b0;
      wait_done("sim_done", d0, 50);
      check("sim_nwr", wr_q.size(), 1);
      if (wr_q.size() > 0) begin
         check("sim_addr", wr_q[0].addr, 483);
         check("sim_before_done", wr_q[0].cyc < done_cyc, 1);
      end

      // raster_start during DRAIN: old frame never signals, buffered pixels still land.
      wr_q.delete();
      mem_if.mem_ready = 1'b0;
      start_frame();
      send_px(8'd1, 8'd1, 24'h0);
      send_px(8'd2, 8'd1, 24'h0);
      d0 = done_cnt;
      raster_done = 1'b1;
      step();
      raster_done = 1'b0;
      step();
      raster_start = 1'b1;
      mem_if.mem_ready = 1'b1;
      step();
      raster_start = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("restart_no_done", done_cnt - d0, 0);
      check("restart_nwr", wr_q.size(), 2);
      end_frame("restart_done", 50);

      // Reset mid-frame drops everything buffered.
      wr_q.delete();
      mem_if.mem_ready = 1'b0;
      start_frame();
      send_px(8'd4, 8'd4, 24'h0);
      send_px(8'd5, 8'd4, 24'h0);
      send_px(8'd6, 8'd4, 24'h0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      mem_if.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("midrst_nwr", wr_q.size(), 0);
      check("midrst_valid", mem_if.mem_valid, 0);

      // Full triangle with random backpressure.
      wr_q.delete();
      n_exp = 0;
      d0 = done_cnt;
      start_frame();
      rand_ready = 1'b1;
      for (int y = 5; y <= 40; y++) begin
         for (int x = 10; x <= 50; x++) begin
            int e0, e1, e2;
            e0 = (50 - 10) * (y - 5)  - (20 - 5)  * (x - 10);
            e1 = (20 - 50) * (y - 20) - (40 - 20) * (x - 50);
            e2 = (10 - 20) * (y - 40) - (5 - 40)  * (x - 20);
            if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
               for (int g = 0; g < 100 && !in_ready; g++) step();
               exp_map[y * FB_W + x] = 1'b1;
               n_exp++;
               send_px(8'(x), 8'(y), {8'(x), 8'(y), 8'h00});
            end
         end
      end
      raster_done = 1'b1;
      step();
      raster_done = 1'b0;
      wait_done("tri_done", d0, 5000);
      rand_ready = 1'b0;
      mem_if.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("tri_one_done", done_cnt - d0, 1);
      check("tri_overflow", overflow, 0);
      check("tri_nwr", wr_q.size(), n_exp);
      bad = 0;
      foreach (wr_q[i]) begin
         int a;
         a = int'(wr_q[i].addr);
         if (a >= FB_W * FB_H || !exp_map[a] || seen[a]) bad++;
         else begin
            seen[a] = 1'b1;
            k = 8'(a % FB_W);
            exp_d = {k[7:3], 6'(((a / FB_W) >> 2) & 63), 5'd0};
            if (wr_q[i].data !== exp_d) bad++;
         end
      end
      check("tri_set", bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
